// File: rtl/duc_skid_pkg.sv
// Shared types and helpers for the DUC skid FIFO and its ring storage.
package duc_skid_pkg;

    localparam int MAX_DEPTH = 64;

    typedef enum logic [1:0] {
        ST_START,
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } state_t;

    // Bits needed to represent an occupancy of 0..depth.
    function automatic int fill_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/duc_skid_ring.sv
// Circular storage behind the output register: one write port, combinational
// read at the read pointer, pointers that wrap at ENTRIES-1 (any entry count).
module duc_skid_ring
    import duc_skid_pkg::*;
#(
    parameter int DW      = 32,
    parameter int ENTRIES = 3
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    input  logic          i_clear,
    input  logic          i_wr_en,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    output logic [DW-1:0] o_rd_data
);

    localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [DW-1:0] mem [ENTRIES];

    // Explicit wrap so non-power-of-two entry counts never touch a hole.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(ENTRIES - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // Pointer advance; clear and reset both return them to the first slot.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n || i_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (i_wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (i_rd_en) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    // Storage write; contents are never reset, occupancy is tracked upstream.
    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            mem[wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem[rd_ptr];

endmodule

// File: rtl/duc_skid_fifo.sv
// Elastic buffer between DUC stages: registered output head entry plus a ring
// of DEPTH-1 entries, fully registered valid/ready on both sides.
module duc_skid_fifo
    import duc_skid_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 4
) (
    input  logic                              i_clock,
    input  logic                              i_reset_n,
    input  logic                              i_flush,
    input  logic [WIDTH*CHANNELS-1:0]         i_in_data,
    input  logic                              i_in_valid,
    output logic                              o_in_ready,
    output logic [WIDTH*CHANNELS-1:0]         o_out_data,
    output logic                              o_out_valid,
    input  logic                              i_out_ready,
    output logic [fill_width(DEPTH)-1:0]      o_fill_level
);

    localparam int DW = WIDTH * CHANNELS;
    localparam int CW = fill_width(DEPTH);

    generate
        if (DEPTH < 2 || DEPTH > MAX_DEPTH) begin : g_depth_check
            $error("duc_skid_fifo: DEPTH out of range 2..MAX_DEPTH");
        end
    endgenerate

    state_t          state_r;
    state_t          state_nxt;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   next_count;
    logic [CW-1:0]   ring_cnt;
    logic            in_ready_r;
    logic            vld_p0;
    logic [DW-1:0]   out_data_p0;
    logic [DW-1:0]   ring_rd_data;
    logic            push;
    logic            pop;
    logic            ring_empty;
    logic            direct;
    logic            ring_wr;
    logic            ring_rd;

    // Handshake decode and routing of the incoming entry.
    always_comb begin
        push       = i_in_valid && in_ready_r;
        pop        = vld_p0 && i_out_ready;
        ring_cnt   = count_r - CW'(vld_p0);
        ring_empty = (ring_cnt == '0);
        direct     = push && ring_empty && (!vld_p0 || pop);
        ring_wr    = push && !direct && !i_flush;
        ring_rd    = pop && !ring_empty && !i_flush;
        if (i_flush) begin
            next_count = '0;
        end else begin
            next_count = count_r + CW'(push) - CW'(pop);
        end
    end

    // Next state follows the occupancy after this edge.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_START: state_nxt = ST_EMPTY;
            default: begin
                if (next_count == '0) begin
                    state_nxt = ST_EMPTY;
                end else if (next_count == CW'(DEPTH)) begin
                    state_nxt = ST_FULL;
                end else begin
                    state_nxt = ST_PARTIAL;
                end
            end
        endcase
    end

    // Control registers: state, count and the registered upstream ready.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_r    <= ST_START;
            count_r    <= '0;
            in_ready_r <= 1'b0;
        end else begin
            state_r    <= state_nxt;
            count_r    <= next_count;
            in_ready_r <= (next_count < CW'(DEPTH));
        end
    end

    // Output register: refill from the ring first, else take the bypass entry.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            vld_p0      <= 1'b0;
            out_data_p0 <= '0;
        end else if (i_flush) begin
            vld_p0 <= 1'b0;
        end else if (pop && !ring_empty) begin
            vld_p0      <= 1'b1;
            out_data_p0 <= ring_rd_data;
        end else if (direct) begin
            vld_p0      <= 1'b1;
            out_data_p0 <= i_in_data;
        end else if (pop) begin
            vld_p0 <= 1'b0;
        end
    end

    duc_skid_ring #(
        .DW      (DW),
        .ENTRIES (DEPTH - 1)
    ) u_ring (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_clear   (i_flush),
        .i_wr_en   (ring_wr),
        .i_wr_data (i_in_data),
        .i_rd_en   (ring_rd),
        .o_rd_data (ring_rd_data)
    );

    assign o_in_ready   = in_ready_r;
    assign o_out_valid  = vld_p0;
    assign o_out_data   = out_data_p0;
    assign o_fill_level = count_r;

endmodule
